// File: rtl/mskreg_bt_pkg.sv
// mskreg_bt_pkg: shared types and helpers for the masked borrowed-time register pipeline
package mskreg_bt_pkg;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    function automatic int share_idx(input int b, input int s, input int d);
        return b * d + s;
    endfunction

    function automatic int clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mskreg_bt_stage.sv
// mskreg_bt_stage: one masked pipeline slot with a clear that refreshes share 0 from rnd
module mskreg_bt_stage
    import mskreg_bt_pkg::*;
#(
    parameter int d          = 2,
    parameter int count      = 8,
    parameter int ZERO_UPPER = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clr,
    input  logic [count*d-1:0] in,
    input  logic [count-1:0]   rnd,
    output logic [count*d-1:0] out,
    input  logic               vin,
    output logic               vout
);

    logic [count*d-1:0] cleared;

    // share 0 of every bit takes fresh randomness; upper shares hold or zero
    always_comb begin
        cleared = out;
        for (int i = 0; i < count; i++) begin
            cleared[share_idx(i, 0, d)] = rnd[i];
            for (int s = 1; s < d; s++)
                if (ZERO_UPPER != 0) cleared[share_idx(i, s, d)] = 1'b0;
        end
    end

    // clear wins over load so a sweep never lets data slip through
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out  <= '0;
            vout <= 1'b0;
        end else if (clr) begin
            out  <= cleared;
            vout <= 1'b0;
        end else if (load) begin
            out  <= in;
            vout <= vin;
        end

endmodule

// File: rtl/mskreg_bt_pipe.sv
// mskreg_bt_pipe: DEPTH-stage masked register pipeline with a one-stage-per-cycle clear sweep
module mskreg_bt_pipe
    import mskreg_bt_pkg::*;
#(
    parameter int d          = 2,
    parameter int count      = 8,
    parameter int DEPTH      = 4,
    parameter int ZERO_UPPER = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [count*d-1:0] in,
    input  logic [count-1:0]   rnd,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [count*d-1:0] out,
    output logic               out_valid
);

    localparam int W  = count * d;
    localparam int IW = clog2(DEPTH);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [W-1:0]    din  [DEPTH];
    logic [W-1:0]    data [DEPTH];
    logic [DEPTH-1:0] vin;
    logic [DEPTH-1:0] v;

    assign in_ready  = en & (state == IDLE) & ~clear_req;
    assign out       = data[DEPTH-1];
    assign out_valid = v[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign din[k] = in;
            assign vin[k] = in_valid;
        end else begin : g_body
            assign din[k] = data[k-1];
            assign vin[k] = v[k-1];
        end
        mskreg_bt_stage #(
            .d(d),
            .count(count),
            .ZERO_UPPER(ZERO_UPPER)
        ) u_stage (
            .clk(clk),
            .rst(rst),
            .load(in_ready),
            .clr((state == SWEEP) && (idx == IW'(k))),
            .in(din[k]),
            .rnd(rnd),
            .out(data[k]),
            .vin(vin[k]),
            .vout(v[k])
        );
    end

    // sweep sequencer: IDLE -> SWEEP over every stage -> one DONE cycle -> IDLE
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (clear_req) begin
                        state      <= SWEEP;
                        idx        <= '0;
                        clear_busy <= 1'b1;
                    end
                SWEEP:
                    if (idx == IW'(DEPTH - 1)) begin
                        state      <= DONE;
                        idx        <= '0;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                DONE: begin
                    state      <= IDLE;
                    clear_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    idx        <= '0;
                    clear_busy <= 1'b0;
                    clear_done <= 1'b0;
                end
            endcase
        end

endmodule

// File: tb/tb_mskreg_bt_pipe.sv
// tb_mskreg_bt_pipe: vector table, corner sequences and random run against a slot-array model
module tb_mskreg_bt_pipe;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst, en, in_valid, clear_req;
    logic [7:0] in;
    logic [3:0] rnd;
    logic       rdy0, rdy1, busy0, busy1, done0, done1, ov0, ov1;
    logic [7:0] out0, out1;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mskreg_bt_pipe #(.d(2), .count(4), .DEPTH(N), .ZERO_UPPER(0)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy0),
        .in(in), .rnd(rnd), .clear_req(clear_req), .clear_busy(busy0),
        .clear_done(done0), .out(out0), .out_valid(ov0)
    );

    mskreg_bt_pipe #(.d(2), .count(4), .DEPTH(N), .ZERO_UPPER(1)) dut_z (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy1),
        .in(in), .rnd(rnd), .clear_req(clear_req), .clear_busy(busy1),
        .clear_done(done1), .out(out1), .out_valid(ov1)
    );

    // reference: slot contents per variant (0 = upper shares kept, 1 = zeroed)
    logic [7:0] m_data [2][N];
    logic       m_valid [N];
    int         m_state;
    int         m_idx;

    typedef struct {
        logic e, iv;
        logic [7:0] din;
        logic [3:0] r;
        logic cr, rdy;
        logic [7:0] o, oz;
        logic ov, b, dn;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic e, iv, input logic [7:0] di, input logic [3:0] r,
                                input logic cr, rdy, input logic [7:0] o, oz, input logic ov, b, dn);
        vec_t x;
        x.e = e; x.iv = iv; x.din = di; x.r = r; x.cr = cr; x.rdy = rdy;
        x.o = o; x.oz = oz; x.ov = ov; x.b = b; x.dn = dn;
        return x;
    endfunction

    function automatic logic [7:0] cleared(input logic [7:0] old, input logic [3:0] r, input int z);
        logic [7:0] x;
        x = old;
        for (int i = 0; i < 4; i++) begin
            x[2*i] = r[i];
            if (z != 0) x[2*i+1] = 1'b0;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int k = 0; k < N; k++) m_data[z][k] = 8'h00;
        for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
        m_state = 0;
        m_idx   = 0;
    endtask

    task automatic model_step();
        if (m_state == 0) begin
            if (clear_req) begin
                m_state = 1;
                m_idx   = 0;
            end else if (en) begin
                for (int k = N - 1; k > 0; k--) begin
                    for (int z = 0; z < 2; z++) m_data[z][k] = m_data[z][k-1];
                    m_valid[k] = m_valid[k-1];
                end
                for (int z = 0; z < 2; z++) m_data[z][0] = in;
                m_valid[0] = in_valid;
            end
        end else if (m_state == 1) begin
            for (int z = 0; z < 2; z++) m_data[z][m_idx] = cleared(m_data[z][m_idx], rnd, z);
            m_valid[m_idx] = 1'b0;
            if (m_idx == N - 1) m_state = 2;
            else m_idx++;
        end else begin
            m_state = 0;
        end
    endtask

    task automatic drive(input logic e, iv, input logic [7:0] di, input logic [3:0] r, input logic cr);
        en = e; in_valid = iv; in = di; rnd = r; clear_req = cr;
        #1;
        chk("in_ready", rdy0, en && m_state == 0 && !clear_req);
        chk("in_ready_z", rdy1, en && m_state == 0 && !clear_req);
    endtask

    task automatic edge_chk();
        @(posedge clk);
        model_step();
        #1;
        chk("out", out0, m_data[0][N-1]);
        chk("out_z", out1, m_data[1][N-1]);
        chk("out_valid", ov0, m_valid[N-1]);
        chk("out_valid_z", ov1, m_valid[N-1]);
        chk("clear_busy", busy0, m_state == 1);
        chk("clear_busy_z", busy1, m_state == 1);
        chk("clear_done", done0, m_state == 2);
        chk("clear_done_z", done1, m_state == 2);
    endtask

    initial begin
        // one-shot word, fill, sweep, simultaneous clear/valid, enable stall
        tbl.push_back(mk(1,1,8'hA5,4'h0,0, 1, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,0, 1, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,0, 1, 8'hA5,8'hA5,1,0,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,0, 1, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(1,1,8'h11,4'h0,0, 1, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(1,1,8'h22,4'h0,0, 1, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(1,1,8'h33,4'h0,0, 1, 8'h11,8'h11,1,0,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,1, 0, 8'h11,8'h11,1,1,0));
        tbl.push_back(mk(1,0,8'h00,4'hF,0, 0, 8'h11,8'h11,1,1,0));
        tbl.push_back(mk(0,0,8'h00,4'h0,0, 0, 8'h11,8'h11,1,1,0));
        tbl.push_back(mk(1,0,8'h00,4'h5,0, 0, 8'h11,8'h11,0,0,1));
        tbl.push_back(mk(1,0,8'h00,4'h0,0, 0, 8'h11,8'h11,0,0,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,0, 1, 8'h22,8'h00,0,0,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,0, 1, 8'h77,8'h55,0,0,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,0, 1, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(1,1,8'h3C,4'h0,1, 0, 8'h00,8'h00,0,1,0));
        tbl.push_back(mk(1,1,8'h3C,4'h0,1, 0, 8'h00,8'h00,0,1,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,1, 0, 8'h00,8'h00,0,1,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,1, 0, 8'h00,8'h00,0,0,1));
        tbl.push_back(mk(1,0,8'h00,4'h0,1, 0, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,0, 1, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,0, 1, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(1,1,8'h5A,4'h0,0, 1, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(0,1,8'h66,4'h0,0, 0, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(0,1,8'h66,4'h0,0, 0, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,0, 1, 8'h00,8'h00,0,0,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,0, 1, 8'h5A,8'h5A,1,0,0));
        tbl.push_back(mk(1,0,8'h00,4'h0,0, 1, 8'h00,8'h00,0,0,0));

        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in = 8'h00; rnd = 4'h0; clear_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out", out0, 8'h00);
        chk("reset_out_valid", ov0, 1'b0);
        chk("reset_busy", busy0, 1'b0);
        chk("reset_done", done0, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].e, tbl[i].iv, tbl[i].din, tbl[i].r, tbl[i].cr);
            chk($sformatf("vec%0d_ready", i), rdy0, tbl[i].rdy);
            edge_chk();
            chk($sformatf("vec%0d_out", i), out0, tbl[i].o);
            chk($sformatf("vec%0d_out_z", i), out1, tbl[i].oz);
            chk($sformatf("vec%0d_valid", i), ov0, tbl[i].ov);
            chk($sformatf("vec%0d_busy", i), busy0, tbl[i].b);
            chk($sformatf("vec%0d_done", i), done0, tbl[i].dn);
        end

        // asynchronous reset while the sweep is at stage index 1
        drive(1, 1, 8'h99, 4'h0, 0); edge_chk();
        drive(1, 0, 8'h00, 4'h0, 0); edge_chk();
        drive(1, 0, 8'h00, 4'h0, 0); edge_chk();
        chk("pre_reset_out", out0, 8'h99);
        drive(1, 0, 8'h00, 4'h0, 1); edge_chk();
        drive(1, 0, 8'h00, 4'hA, 0); edge_chk();
        chk("pre_reset_busy", busy0, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_out", out0, 8'h00);
        chk("async_rst_out_valid", ov0, 1'b0);
        chk("async_rst_busy", busy0, 1'b0);
        chk("async_rst_busy_z", busy1, 1'b0);
        model_reset();
        #2 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1, 0, 8'h00, 4'h0, 0);
            chk("post_rst_ready", rdy0, 1'b1);
            edge_chk();
            chk("post_rst_no_done", done0, 1'b0);
        end

        for (int c = 0; c < 500; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 4'($urandom),
                  1'($urandom_range(0, 9) == 0));
            edge_chk();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
